fsm_seq_driver: RTL

- Serial-stimulus transmitter and response capturer for the single-bit-in / single-bit-out Mealy machines built in the activity series (8-state original and reduced equivalents).
- Accepts a parallel pattern word and a length, resets the target machine, then drives the pattern onto `x_out` one bit per clock.
- Samples the target's `y` on each of those cycles and returns the collected response as a parallel word with a done pulse.
- Sits beside the machine under comparison so original and reduced implementations can be driven with identical sequences and their response words compared.

---
 rtl/fsm_seq_driver_pkg.sv | 25 ++
 rtl/fsm_seq_driver_bit_shifter.sv | 60 ++++++
 rtl/fsm_seq_driver.sv | 113 +++++++++++
 3 files changed

// File: rtl/fsm_seq_driver_pkg.sv
// Shared types for the sequence driver and the activity-series Mealy machines.
// Holds the driver state encoding, the default word width and the S0-S7 machine states.
package fsm_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } drv_state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } fsm_state_t;

endpackage

// File: rtl/fsm_seq_driver_bit_shifter.sv
// Stimulus shift-out register paired with a response capture register.
// Response bits land at the same position the matching stimulus bit came from.
module bit_shifter
    import fsm_seq_pkg::*;
#(
    parameter int  WIDTH     = DEFAULT_WIDTH,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int IW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             shift_en,
    input  logic             capture_en,
    input  logic             capture_bit,
    output logic             head_bit,
    output logic [WIDTH-1:0] resp_next
);

    logic [WIDTH-1:0] stim;
    logic [WIDTH-1:0] resp_acc;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    pos;

    assign head_bit = LSB_FIRST ? stim[0] : stim[WIDTH-1];
    assign pos      = LSB_FIRST ? idx : (IW'(WIDTH - 1) - idx);

    // resp_next already includes the bit being sampled this edge, so the
    // top can publish the complete word on the same edge that ends SHIFT.
    always_comb begin
        resp_next = resp_acc;
        for (int i = 0; i < WIDTH; i++) begin
            if (capture_en && (pos == IW'(i))) begin
                resp_next[i] = capture_bit;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stim     <= '0;
            resp_acc <= '0;
            idx      <= '0;
        end else if (load) begin
            stim     <= load_word;
            resp_acc <= '0;
            idx      <= '0;
        end else begin
            if (shift_en) begin
                stim <= LSB_FIRST ? {1'b0, stim[WIDTH-1:1]} : {stim[WIDTH-2:0], 1'b0};
            end
            if (capture_en) begin
                resp_acc <= resp_next;
                idx      <= idx + IW'(1);
            end
        end
    end

endmodule

// File: rtl/fsm_seq_driver.sv
// Drives a parallel pattern serially into a single-bit Mealy machine after
// resetting it, and returns the machine's per-cycle response as a parallel word.
module fsm_seq_driver
    import fsm_seq_pkg::*;
#(
    parameter int  WIDTH     = DEFAULT_WIDTH,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int LW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LW-1:0]    len,
    output logic             busy,
    output logic             fsm_rst,
    output logic             x_out,
    input  logic             y_in,
    output logic [WIDTH-1:0] resp,
    output logic             done
);

    drv_state_t       state;
    logic [LW-1:0]    cnt;
    logic [LW-1:0]    len_clamped;
    logic             load;
    logic             shift_en;
    logic             capture_en;
    logic             head_bit;
    logic [WIDTH-1:0] resp_next;

    assign len_clamped = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
    assign load        = (state == IDLE) && start;
    assign capture_en  = (state == SHIFT);
    // The stimulus register runs one bit ahead of x_out, so it advances on
    // the edge that loads x_out and stops once the last bit has been issued.
    assign shift_en    = ((state == RST) && (cnt != '0)) ||
                         ((state == SHIFT) && (cnt != LW'(1)));

    bit_shifter #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_word   (pattern),
        .shift_en    (shift_en),
        .capture_en  (capture_en),
        .capture_bit (y_in),
        .head_bit    (head_bit),
        .resp_next   (resp_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            fsm_rst <= 1'b0;
            x_out   <= 1'b0;
            done    <= 1'b0;
            resp    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= RST;
                        cnt     <= len_clamped;
                        busy    <= 1'b1;
                        fsm_rst <= 1'b1;
                    end
                end
                RST: begin
                    fsm_rst <= 1'b0;
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                        resp  <= resp_next;
                    end else begin
                        state <= SHIFT;
                        x_out <= head_bit;
                    end
                end
                SHIFT: begin
                    cnt <= cnt - LW'(1);
                    if (cnt == LW'(1)) begin
                        state <= DONE;
                        x_out <= 1'b0;
                        done  <= 1'b1;
                        resp  <= resp_next;
                    end else begin
                        x_out <= head_bit;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    fsm_rst <= 1'b0;
                    x_out   <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
